// File: rtl/pio_irq_sequencer_pkg.sv
// Shared FSM state codes, PIO register offsets and bus-request helpers
// for the PIO interrupt sequencer.
package pio_seq_pkg;

    localparam logic [3:0] S_INIT     = 4'd0;
    localparam logic [3:0] S_IDLE     = 4'd1;
    localparam logic [3:0] S_MASK_OFF = 4'd2;
    localparam logic [3:0] S_HOLD     = 4'd3;
    localparam logic [3:0] S_RD_ADDR  = 4'd4;
    localparam logic [3:0] S_RD_CAPT  = 4'd5;
    localparam logic [3:0] S_LED_WR   = 4'd6;
    localparam logic [3:0] S_REL_ADDR = 4'd7;
    localparam logic [3:0] S_REL_CAPT = 4'd8;
    localparam logic [3:0] S_REARM    = 4'd9;

    localparam logic [1:0] DATA_OFS = 2'd0;
    localparam logic [1:0] MASK_OFS = 2'd2;

    typedef struct packed {
        logic        in_cs;
        logic        led_cs;
        logic        write_n;
        logic [1:0]  address;
        logic [31:0] writedata;
    } bus_req_t;

    localparam bus_req_t BUS_IDLE = '{in_cs: 1'b0, led_cs: 1'b0, write_n: 1'b1,
                                      address: 2'd0, writedata: 32'd0};

    function automatic bus_req_t pio_wr(input logic to_led, input logic [1:0] ofs,
                                        input logic [31:0] data);
        bus_req_t r;
        r           = BUS_IDLE;
        r.in_cs     = !to_led;
        r.led_cs    = to_led;
        r.write_n   = 1'b0;
        r.address   = ofs;
        r.writedata = data;
        return r;
    endfunction

    function automatic bus_req_t pio_rd(input logic [1:0] ofs);
        bus_req_t r;
        r         = BUS_IDLE;
        r.in_cs   = 1'b1;
        r.address = ofs;
        return r;
    endfunction

endpackage

// File: rtl/pio_irq_sequencer_if.sv
// Shared Avalon-MM style bus towards the input PIO and the LED PIO.
interface pio_irq_sequencer_if;
    logic [1:0]  avm_address;
    logic [31:0] avm_writedata;
    logic        avm_write_n;
    logic        in_cs;
    logic [31:0] in_readdata;
    logic        led_cs;

    modport master (output avm_address, avm_writedata, avm_write_n, in_cs, led_cs,
                    input  in_readdata);
    modport slave  (input  avm_address, avm_writedata, avm_write_n, in_cs, led_cs,
                    output in_readdata);
endinterface

// File: rtl/pio_irq_sequencer_holdoff.sv
// Debounce holdoff down-counter: loads on request, counts to zero, flags done.
module pio_seq_holdoff #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/pio_irq_sequencer.sv
// Services input-PIO interrupts: mask, debounce, capture, mirror to LEDs,
// wait for release, then re-arm the mask.
module pio_irq_sequencer
    import pio_seq_pkg::*;
#(
    parameter int             DW        = 4,
    parameter int             LW        = 8,
    parameter logic [DW-1:0]  MASK_INIT = 4'hF,
    parameter int             HOLDOFF   = 50000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      in_irq,
    pio_irq_sequencer_if.master       bus,
    output logic                      busy,
    output logic [7:0]                event_count,
    output logic [DW-1:0]             last_value
);
    localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [3:0]    state_q, state_d;
    bus_req_t      bus_q, bus_d;
    logic          busy_q, busy_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [DW-1:0] lv_q, lv_d;
    logic [DW-1:0] sample;
    logic [LW-1:0] led_data;
    logic          hold_load, hold_done;
    logic          unused_rd;

    assign sample    = bus.in_readdata[DW-1:0];
    assign unused_rd = ^bus.in_readdata[31:DW];
    assign hold_load = (state_d == S_HOLD) && (state_q != S_HOLD);

    pio_seq_holdoff #(.CW(HCW)) u_holdoff (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (hold_load),
        .load_val (HCW'(HOLDOFF - 1)),
        .done     (hold_done)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lv_d    = lv_q;
        case (state_q)
            S_INIT:     state_d = S_IDLE;
            S_IDLE:     if (in_irq && en) state_d = S_MASK_OFF;
            S_MASK_OFF: state_d = S_HOLD;
            S_HOLD:     if (hold_done) state_d = S_RD_ADDR;
            S_RD_ADDR:  state_d = S_RD_CAPT;
            S_RD_CAPT: begin
                lv_d = sample;
                if (sample != '0) cnt_d = cnt_q + 8'd1;
                state_d = S_LED_WR;
            end
            // A zero capture already proves the inputs are released: no polling.
            S_LED_WR:   state_d = (lv_q == '0) ? S_REARM : S_REL_ADDR;
            S_REL_ADDR: state_d = S_REL_CAPT;
            S_REL_CAPT: state_d = (sample == '0) ? S_REARM : S_REL_ADDR;
            S_REARM:    state_d = S_IDLE;
            default:    state_d = S_INIT;
        endcase
    end

    // Bus registers are loaded from the next state so they line up with
    // state_q; INIT is the exception because it is left on the first edge.
    assign led_data = {cnt_d[LW-DW-1:0], lv_d};

    always_comb begin
        bus_d = BUS_IDLE;
        if (state_q == S_INIT)
            bus_d = pio_wr(1'b0, MASK_OFS, 32'(MASK_INIT));
        else begin
            case (state_d)
                S_MASK_OFF:           bus_d = pio_wr(1'b0, MASK_OFS, 32'd0);
                S_RD_ADDR, S_REL_ADDR: bus_d = pio_rd(DATA_OFS);
                S_LED_WR:             bus_d = pio_wr(1'b1, DATA_OFS, 32'(led_data));
                S_REARM:              bus_d = pio_wr(1'b0, MASK_OFS, 32'(MASK_INIT));
                default:              bus_d = BUS_IDLE;
            endcase
        end
        busy_d = (state_q == S_INIT) || (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            bus_q   <= BUS_IDLE;
            busy_q  <= 1'b1;
            cnt_q   <= 8'd0;
            lv_q    <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            lv_q    <= lv_d;
        end
    end

    assign bus.in_cs         = bus_q.in_cs;
    assign bus.led_cs        = bus_q.led_cs;
    assign bus.avm_write_n   = bus_q.write_n;
    assign bus.avm_address   = bus_q.address;
    assign bus.avm_writedata = bus_q.writedata;
    assign busy              = busy_q;
    assign event_count       = cnt_q;
    assign last_value        = lv_q;
endmodule

// File: tb/tb_pio_irq_sequencer.sv
// Directed bench for pio_irq_sequencer with a small input-PIO/LED-PIO model.
module tb_pio_irq_sequencer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       in_irq;
    logic       busy;
    logic [7:0] event_count;
    logic [3:0] last_value;
    logic [3:0] pin = 4'd0;
    logic [3:0] mask_m = 4'd0;
    logic [31:0] led_m = 32'd0;
    int vectors = 0;
    int miscompares = 0;

    localparam logic [36:0] B_IDLE  = {1'b0, 1'b0, 1'b1, 2'd0, 32'd0};
    localparam logic [36:0] B_MASKF = {1'b1, 1'b0, 1'b0, 2'd2, 32'hF};
    localparam logic [36:0] B_MASK0 = {1'b1, 1'b0, 1'b0, 2'd2, 32'h0};
    localparam logic [36:0] B_RD    = {1'b1, 1'b0, 1'b1, 2'd0, 32'd0};

    pio_irq_sequencer_if bif ();

    pio_irq_sequencer #(.DW(4), .LW(8), .MASK_INIT(4'hF), .HOLDOFF(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .in_irq      (in_irq),
        .bus         (bif),
        .busy        (busy),
        .event_count (event_count),
        .last_value  (last_value)
    );

    always #5 clk = ~clk;

    // Input PIO: data at offset 0 (registered read), irq mask at offset 2.
    assign in_irq = |(pin & mask_m);
    always @(posedge clk) begin
        if (bif.in_cs && !bif.avm_write_n && bif.avm_address == 2'd2)
            mask_m <= bif.avm_writedata[3:0];
        if (bif.in_cs && bif.avm_write_n && bif.avm_address == 2'd0)
            bif.in_readdata <= {28'd0, pin};
        if (bif.led_cs && !bif.avm_write_n)
            led_m <= bif.avm_writedata;
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            vectors++;
            assert (!(bif.in_cs && bif.led_cs) && (bif.avm_write_n || bif.in_cs || bif.led_cs))
            else begin
                miscompares++;
                $error("FAIL bus_excl: in_cs=%0b led_cs=%0b write_n=%0b", bif.in_cs, bif.led_cs,
                       bif.avm_write_n);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [36:0] busv();
        return {bif.in_cs, bif.led_cs, bif.avm_write_n, bif.avm_address, bif.avm_writedata};
    endfunction

    function automatic logic [36:0] b_led(input logic [31:0] d);
        return {1'b0, 1'b1, 1'b0, 2'd0, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_led(output logic [31:0] wd);
        int n = 0;
        while (!(bif.led_cs && !bif.avm_write_n) && n < 64) begin
            tick();
            n++;
        end
        chk("led_timeout", 64'(n < 64), 64'd1);
        wd = bif.avm_writedata;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 64) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(n < 64), 64'd1);
    endtask

    task automatic service(input logic [3:0] v, output logic [31:0] wd);
        pin = v;
        wait_led(wd);
        pin = 4'd0;
        wait_idle();
    endtask

    initial begin
        logic [31:0] wd;
        bif.in_readdata = 32'd0;
        reset_n = 1'b0;
        en = 1'b0;
        repeat (3) tick();
        chk("rst_bus", 64'(busv()), 64'(B_IDLE));
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_cnt", 64'(event_count), 64'd0);
        chk("rst_lv", 64'(last_value), 64'd0);

        // Reset release: one mask write of 0xF, then idle.
        reset_n = 1'b1;
        tick();
        chk("init_wr", 64'(busv()), 64'(B_MASKF));
        chk("init_busy", 64'(busy), 64'd1);
        tick();
        chk("init_idle", 64'(busv()), 64'(B_IDLE));
        chk("init_busy0", 64'(busy), 64'd0);
        chk("init_mask", 64'(mask_m), 64'hF);

        // Full service with input 0010, holdoff of 4 cycles.
        en = 1'b1;
        pin = 4'b0010;
        tick();
        chk("s1_maskoff", 64'(busv()), 64'(B_MASK0));
        chk("s1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s1_hold", 64'(busv()), 64'(B_IDLE));
        end
        tick();
        chk("s1_rd", 64'(busv()), 64'(B_RD));
        tick();
        chk("s1_capt", 64'(busv()), 64'(B_IDLE));
        tick();
        chk("s1_led", 64'(busv()), 64'(b_led(32'h12)));
        chk("s1_lv", 64'(last_value), 64'd2);
        chk("s1_cnt", 64'(event_count), 64'd1);
        tick();
        chk("s1_poll1", 64'(busv()), 64'(B_RD));
        tick();
        tick();
        chk("s1_poll2", 64'(busv()), 64'(B_RD));
        chk("s1_poll_lv", 64'(last_value), 64'd2);
        chk("s1_poll_cnt", 64'(event_count), 64'd1);
        pin = 4'd0;
        tick();
        tick();
        chk("s1_rearm", 64'(busv()), 64'(B_MASKF));
        tick();
        chk("s1_idle", 64'(busv()), 64'(B_IDLE));
        chk("s1_busy0", 64'(busy), 64'd0);
        chk("s1_ledm", 64'(led_m), 64'h12);

        // Glitch: input high for 2 cycles only, captured as zero.
        pin = 4'b0001;
        tick();
        chk("gl_maskoff", 64'(busv()), 64'(B_MASK0));
        tick();
        pin = 4'd0;
        repeat (3) tick();
        tick();
        chk("gl_rd", 64'(busv()), 64'(B_RD));
        tick();
        tick();
        chk("gl_led", 64'(busv()), 64'(b_led(32'h10)));
        chk("gl_cnt", 64'(event_count), 64'd1);
        chk("gl_lv", 64'(last_value), 64'd0);
        tick();
        chk("gl_rearm", 64'(busv()), 64'(B_MASKF));
        tick();
        chk("gl_busy0", 64'(busy), 64'd0);

        // Count up to 255, then one more service wraps to 0.
        for (int i = 0; i < 254; i++) service(4'(i % 15 + 1), wd);
        chk("wr_cnt255", 64'(event_count), 64'd255);
        service(4'd3, wd);
        chk("wr_led", 64'(wd), 64'h03);
        chk("wr_cnt0", 64'(event_count), 64'd0);
        chk("wr_lv", 64'(last_value), 64'd3);

        // en dropped during HOLD: service still completes.
        pin = 4'b0100;
        tick();
        chk("en_maskoff", 64'(busv()), 64'(B_MASK0));
        tick();
        en = 1'b0;
        wait_led(wd);
        chk("en_led", 64'(wd), 64'h14);
        pin = 4'd0;
        wait_idle();
        chk("en_mask", 64'(mask_m), 64'hF);
        chk("en_cnt", 64'(event_count), 64'd1);
        pin = 4'b1000;
        repeat (10) tick();
        chk("en_hold_busy", 64'(busy), 64'd0);
        chk("en_hold_bus", 64'(busv()), 64'(B_IDLE));
        en = 1'b1;
        tick();
        chk("en_resume", 64'(busv()), 64'(B_MASK0));
        wait_led(wd);
        chk("en_led2", 64'(wd), 64'h28);
        pin = 4'd0;
        wait_idle();
        chk("en_cnt2", 64'(event_count), 64'd2);

        // Reset pulsed while polling for release.
        pin = 4'b0101;
        wait_led(wd);
        chk("rp_led", 64'(wd), 64'h35);
        repeat (3) tick();
        chk("rp_poll", 64'(busv()), 64'(B_RD));
        #2;
        reset_n = 1'b0;
        pin = 4'd0;
        #1;
        chk("rp_async_bus", 64'(busv()), 64'(B_IDLE));
        chk("rp_async_busy", 64'(busy), 64'd1);
        chk("rp_async_cnt", 64'(event_count), 64'd0);
        chk("rp_async_lv", 64'(last_value), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rp_init_wr", 64'(busv()), 64'(B_MASKF));
        tick();
        chk("rp_idle", 64'(busv()), 64'(B_IDLE));
        chk("rp_busy0", 64'(busy), 64'd0);
        chk("rp_cnt", 64'(event_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
